kmer_builder: RTL and testbench
===============================

KMER_BUILDER -- requirements
Module: kmer_builder

Interface
REQ-001 Parameter KMER_LEN, default 16, means bases per k-mer; each base is 2 bits, so a k-mer is 32 bits.
REQ-002 Parameter NUM_KMERS, default 49, means k-mers per sequence; the sequence length is NUM_KMERS+KMER_LEN-1 = 64 bases.
REQ-003 clk  input  1  is the single clock; all logic is on its rising edge.
REQ-004 rstN  input  1  is a synchronous, active-high reset.
REQ-005 charIn  input  8  is an ASCII nucleotide character.
REQ-006 charValid  input  1  means charIn is valid this cycle.
REQ-007 charReady  output  1  means the block accepts charIn this cycle.
REQ-008 seqRestart  input  1  is a synchronous abort of the sequence in progress.
REQ-009 kmersSeq  output  [48:0][31:0]  is the packed k-mer array presented to the similarity engine (kmersSeqOne/kmersSeqTwo).
REQ-010 kmersValid  output  1  means kmersSeq is complete and stable.
REQ-011 kmersAck  input  1  means the consumer has taken kmersSeq.
REQ-012 badChar  output  1  is a one-cycle pulse when an accepted character is not a nucleotide.
REQ-013 baseCount  output  7  is the number of valid bases accepted so far in the current sequence (0..64).

Function
REQ-014 The base encoding SHALL be case-insensitive: A=00, C=01, G=10, T=11.
REQ-015 A transfer SHALL occur only when charValid and charReady are both 1.
REQ-016 The block SHALL have two states, FILL and HOLD.
REQ-017 In FILL, charReady=1, kmersValid=0, and each valid base SHALL update the window as window <= {window[29:0], code} and increment baseCount.
REQ-018 When a base brings baseCount from n-1 to n with n>=16, kmersSeq[n-16] SHALL be written with the new window value in the same edge.
- The first base of each k-mer therefore occupies bits [31:30].
REQ-019 kmersSeq[i] SHALL equal bases i..i+15 of the sequence.
REQ-020 On acceptance of the 64th base, the state SHALL go FILL->HOLD, and kmersValid SHALL be 1 from the next cycle.
- Latency is one cycle from the last base to kmersValid.
REQ-021 In HOLD, charReady=0, kmersValid=1, and kmersSeq SHALL not change.
- charValid is ignored.
REQ-022 kmersAck in HOLD SHALL move the state to FILL on the next edge and clear baseCount and the window.
- kmersSeq keeps its old contents until overwritten.
- kmersAck in FILL is ignored.
REQ-023 An accepted non-nucleotide character SHALL pulse badChar for exactly one cycle.
- The character is consumed and discarded.
- The window and baseCount are unchanged.
REQ-024 seqRestart in FILL SHALL clear baseCount and the window next cycle, and any character transferred in the same cycle SHALL be discarded.
REQ-025 seqRestart in HOLD SHALL behave as kmersAck.
REQ-026 If seqRestart and kmersAck are asserted together, the behaviour SHALL be that of a single kmersAck.
REQ-027 baseCount SHALL saturate at 64 and never wrap.

Reset
REQ-028 rstN=1 at a clock edge SHALL force:
- state FILL
- baseCount=0
- window=0
- all kmersSeq words=0
- kmersValid=0
- badChar=0
- charReady=1 from the following cycle
REQ-029 Reset SHALL take priority over all other inputs, including mid-fill and during HOLD.
- Any partial sequence is lost.

Verification
REQ-030 64 x 'A' with continuous charValid -> kmersValid=1 exactly one cycle after the 64th transfer, and all 49 words are 0x00000000.
REQ-031 64 x 't' -> all 49 words are 0xFFFFFFFF.
REQ-032 "ACGT" repeated 16 times -> kmersSeq[0]=0x1B1B1B1B, kmersSeq[1]=0x6C6C6C6C, and kmersSeq[48]=0x1B1B1B1B.
REQ-033 "ACGT"x16 with 'N' inserted after base 20 -> one badChar pulse, baseCount stays 20 across the 'N', and the result is identical to REQ-032.
REQ-034 With kmersAck withheld 10 cycles while charValid=1 -> charReady=0 and kmersSeq is stable throughout; after kmersAck, charReady=1 and baseCount=0 next cycle.
REQ-035 rstN pulsed after 30 bases, then 64 x 'C' -> all words are 0x55555555, with no residue from the first 30 bases.

Source files
------------

// File: rtl/kmer_builder_if.sv
// Character-in / k-mer-array-out bundle between a sequence reader and the k-mer builder.
// master = reader/consumer side, slave = kmer_builder.
interface kmer_builder_if #(
    parameter int KMER_LEN  = 16,
    parameter int NUM_KMERS = 49
);
    localparam int WORD_W  = 2 * KMER_LEN;
    localparam int SEQ_LEN = NUM_KMERS + KMER_LEN - 1;
    localparam int CNT_W   = $clog2(SEQ_LEN + 1);

    logic [7:0]                        charIn;
    logic                              charValid;
    logic                              charReady;
    logic                              seqRestart;
    logic [NUM_KMERS-1:0][WORD_W-1:0]  kmersSeq;
    logic                              kmersValid;
    logic                              kmersAck;
    logic                              badChar;
    logic [CNT_W-1:0]                  baseCount;

    modport master (
        output charIn, charValid, seqRestart, kmersAck,
        input  charReady, kmersSeq, kmersValid, badChar, baseCount
    );

    modport slave (
        input  charIn, charValid, seqRestart, kmersAck,
        output charReady, kmersSeq, kmersValid, badChar, baseCount
    );
endinterface

// File: rtl/kmer_builder.sv
// Packs an ASCII nucleotide stream into overlapping 2-bit-per-base k-mers; kmersValid one cycle after the last base.
// Backpressure: charReady drops while the finished array is held, until kmersAck or seqRestart.
module kmer_builder #(
    parameter int KMER_LEN  = 16,
    parameter int NUM_KMERS = 49
) (
    input  logic           clk,
    input  logic           rstN,
    kmer_builder_if.slave  bus
);
    localparam int WORD_W  = 2 * KMER_LEN;
    localparam int SEQ_LEN = NUM_KMERS + KMER_LEN - 1;
    localparam int CNT_W   = $clog2(SEQ_LEN + 1);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(SEQ_LEN);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(KMER_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                            state;
    state_t                            state_nxt;
    logic [WORD_W-1:0]                 window;
    logic [WORD_W-1:0]                 window_shift;
    logic [CNT_W-1:0]                  base_count;
    logic [CNT_W-1:0]                  count_inc;
    logic [CNT_W-1:0]                  wr_idx;
    logic [NUM_KMERS-1:0][WORD_W-1:0]  kmers;
    logic                              bad_char;
    logic [1:0]                        code;
    logic                              is_base;
    logic                              take;
    logic                              shift_en;
    logic                              clear_en;
    logic                              bad_nxt;
    logic                              wr_en;

    always_comb begin
        code    = 2'b00;
        is_base = 1'b0;
        case (bus.charIn)
            8'h41, 8'h61: begin code = 2'b00; is_base = 1'b1; end
            8'h43, 8'h63: begin code = 2'b01; is_base = 1'b1; end
            8'h47, 8'h67: begin code = 2'b10; is_base = 1'b1; end
            8'h54, 8'h74: begin code = 2'b11; is_base = 1'b1; end
            default:      begin code = 2'b00; is_base = 1'b0; end
        endcase
    end

    // The count never passes CNT_FULL: reaching it moves us to HOLD, where nothing is shifted.
    assign count_inc    = (base_count == CNT_FULL) ? base_count : base_count + CNT_ONE;
    assign window_shift = (window << 2) | WORD_W'(code);
    assign wr_en        = shift_en && (count_inc >= CNT_FIRST);
    assign wr_idx       = count_inc - CNT_FIRST;

    always_ff @(posedge clk) begin
        if (rstN) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        shift_en       = 1'b0;
        clear_en       = 1'b0;
        bad_nxt        = 1'b0;
        bus.charReady  = 1'b0;
        bus.kmersValid = 1'b0;
        take           = 1'b0;
        case (state)
            FILL: begin
                bus.charReady = 1'b1;
                take          = bus.charValid;
                // Restart wins over a character landing in the same cycle.
                if (bus.seqRestart) begin
                    clear_en = 1'b1;
                end else if (take && is_base) begin
                    shift_en = 1'b1;
                    if (count_inc == CNT_FULL) begin
                        state_nxt = HOLD;
                    end
                end else if (take) begin
                    bad_nxt = 1'b1;
                end
            end
            HOLD: begin
                bus.kmersValid = 1'b1;
                if (bus.kmersAck || bus.seqRestart) begin
                    clear_en  = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstN) begin
            window     <= '0;
            base_count <= '0;
            kmers      <= '0;
            bad_char   <= 1'b0;
        end else begin
            bad_char <= bad_nxt;
            if (clear_en) begin
                window     <= '0;
                base_count <= '0;
            end else if (shift_en) begin
                window     <= window_shift;
                base_count <= count_inc;
            end
            // Old k-mers survive an ack; they are only overwritten by the next fill.
            for (int i = 0; i < NUM_KMERS; i++) begin
                if (wr_en && (wr_idx == CNT_W'(i))) begin
                    kmers[i] <= window_shift;
                end
            end
        end
    end

    assign bus.kmersSeq  = kmers;
    assign bus.badChar   = bad_char;
    assign bus.baseCount = base_count;

    a_hold_stable: assert property (@(posedge clk) disable iff (rstN)
        (state == HOLD) |=> $stable(kmers));

    a_hold_full: assert property (@(posedge clk) disable iff (rstN)
        (state == HOLD) |-> (base_count == CNT_FULL));

    a_count_range: assert property (@(posedge clk) disable iff (rstN)
        base_count <= CNT_FULL);

endmodule

// File: tb/tb_kmer_builder.sv
// Directed, table-driven bench for kmer_builder.
module tb_kmer_builder;
    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    kmer_builder_if #(.KMER_LEN(16), .NUM_KMERS(49)) bus();

    kmer_builder #(.KMER_LEN(16), .NUM_KMERS(49)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string             pat;
        int                bad_pos;
        logic [3:0][31:0]  exp;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [3:0][31:0] mk(logic [31:0] a, logic [31:0] b,
                                            logic [31:0] c, logic [31:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_char(input byte c);
        bus.charIn    = c;
        bus.charValid = 1'b1;
        tick();
        bus.charValid = 1'b0;
    endtask

    task automatic send_seq(input string pat, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            send_char(pat[i % pat.len()]);
        end
    endtask

    task automatic check_words(input string name, input logic [3:0][31:0] exp);
        for (int i = 0; i < 49; i++) begin
            chk($sformatf("%s word%0d", name, i), bus.kmersSeq[i], exp[i % 4]);
        end
    endtask

    task automatic run_vec(input int k, input bit ack);
        string p;
        int    b;
        string nm;
        p  = tbl[k].pat;
        b  = tbl[k].bad_pos;
        nm = $sformatf("vec%0d", k);
        if (b >= 0) begin
            send_seq(p, 0, b);
            send_char("N");
            chk({nm, " badChar pulse"}, 32'(bus.badChar), 32'd1);
            chk({nm, " count at bad"}, 32'(bus.baseCount), b);
            send_seq(p, b, 1);
            chk({nm, " badChar end"}, 32'(bus.badChar), 32'd0);
            send_seq(p, b + 1, 62 - b);
        end else begin
            send_seq(p, 0, 63);
        end
        chk({nm, " valid before last"}, 32'(bus.kmersValid), 32'd0);
        chk({nm, " count 63"}, 32'(bus.baseCount), 32'd63);
        chk({nm, " ready before last"}, 32'(bus.charReady), 32'd1);
        send_seq(p, 63, 1);
        chk({nm, " valid after last"}, 32'(bus.kmersValid), 32'd1);
        chk({nm, " ready in hold"}, 32'(bus.charReady), 32'd0);
        chk({nm, " count 64"}, 32'(bus.baseCount), 32'd64);
        check_words(nm, tbl[k].exp);
        if (ack) begin
            bus.kmersAck = 1'b1;
            tick();
            bus.kmersAck = 1'b0;
            chk({nm, " ready after ack"}, 32'(bus.charReady), 32'd1);
            chk({nm, " count after ack"}, 32'(bus.baseCount), 32'd0);
            chk({nm, " valid after ack"}, 32'(bus.kmersValid), 32'd0);
        end
    endtask

    initial begin
        tbl[0] = '{pat: "A",    bad_pos: -1, exp: mk(32'h0, 32'h0, 32'h0, 32'h0)};
        tbl[1] = '{pat: "t",    bad_pos: -1, exp: mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF)};
        tbl[2] = '{pat: "ACGT", bad_pos: -1, exp: mk(32'h1B1B1B1B, 32'h6C6C6C6C, 32'hB1B1B1B1, 32'hC6C6C6C6)};
        tbl[3] = '{pat: "ACGT", bad_pos: 20, exp: mk(32'h1B1B1B1B, 32'h6C6C6C6C, 32'hB1B1B1B1, 32'hC6C6C6C6)};
        tbl[4] = '{pat: "acgt", bad_pos: -1, exp: mk(32'h1B1B1B1B, 32'h6C6C6C6C, 32'hB1B1B1B1, 32'hC6C6C6C6)};
        tbl[5] = '{pat: "g",    bad_pos: -1, exp: mk(32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA)};
        tbl[6] = '{pat: "C",    bad_pos: -1, exp: mk(32'h55555555, 32'h55555555, 32'h55555555, 32'h55555555)};

        bus.charIn     = 8'h00;
        bus.charValid  = 1'b0;
        bus.seqRestart = 1'b0;
        bus.kmersAck   = 1'b0;
        rstN           = 1'b1;
        tick();
        tick();
        chk("reset ready", 32'(bus.charReady), 32'd1);
        chk("reset valid", 32'(bus.kmersValid), 32'd0);
        chk("reset badChar", 32'(bus.badChar), 32'd0);
        chk("reset count", 32'(bus.baseCount), 32'd0);
        check_words("reset", mk(32'h0, 32'h0, 32'h0, 32'h0));
        rstN = 1'b0;

        for (int k = 0; k < 7; k++) begin
            run_vec(k, 1'b1);
        end

        // Consumer withholds the ack for 10 cycles while the reader keeps pushing.
        run_vec(2, 1'b0);
        for (int c = 0; c < 10; c++) begin
            bus.charIn    = "C";
            bus.charValid = 1'b1;
            tick();
            chk("hold ready", 32'(bus.charReady), 32'd0);
            chk("hold valid", 32'(bus.kmersValid), 32'd1);
            chk("hold count", 32'(bus.baseCount), 32'd64);
            check_words("hold", tbl[2].exp);
        end
        bus.charValid = 1'b0;
        bus.kmersAck  = 1'b1;
        tick();
        bus.kmersAck  = 1'b0;
        chk("late ack ready", 32'(bus.charReady), 32'd1);
        chk("late ack count", 32'(bus.baseCount), 32'd0);
        chk("late ack valid", 32'(bus.kmersValid), 32'd0);
        chk("late ack keeps word0", bus.kmersSeq[0], 32'h1B1B1B1B);

        // Ack in FILL does nothing.
        send_seq("A", 0, 5);
        bus.kmersAck = 1'b1;
        tick();
        bus.kmersAck = 1'b0;
        chk("fill ack count", 32'(bus.baseCount), 32'd5);
        chk("fill ack ready", 32'(bus.charReady), 32'd1);

        // Restart in FILL drops the character transferred alongside it.
        bus.seqRestart = 1'b1;
        send_char("G");
        bus.seqRestart = 1'b0;
        chk("restart count", 32'(bus.baseCount), 32'd0);
        run_vec(6, 1'b1);

        // Restart together with ack in HOLD acts as one ack.
        run_vec(1, 1'b0);
        bus.seqRestart = 1'b1;
        bus.kmersAck   = 1'b1;
        tick();
        bus.seqRestart = 1'b0;
        bus.kmersAck   = 1'b0;
        chk("restart+ack ready", 32'(bus.charReady), 32'd1);
        chk("restart+ack count", 32'(bus.baseCount), 32'd0);
        chk("restart+ack valid", 32'(bus.kmersValid), 32'd0);
        tick();
        chk("restart+ack stays fill", 32'(bus.charReady), 32'd1);

        // Restart alone in HOLD.
        run_vec(5, 1'b0);
        bus.seqRestart = 1'b1;
        tick();
        bus.seqRestart = 1'b0;
        chk("hold restart ready", 32'(bus.charReady), 32'd1);
        chk("hold restart count", 32'(bus.baseCount), 32'd0);
        chk("hold restart valid", 32'(bus.kmersValid), 32'd0);

        // Reset during HOLD.
        run_vec(1, 1'b0);
        rstN = 1'b1;
        tick();
        rstN = 1'b0;
        chk("hold reset valid", 32'(bus.kmersValid), 32'd0);
        chk("hold reset ready", 32'(bus.charReady), 32'd1);
        chk("hold reset count", 32'(bus.baseCount), 32'd0);
        chk("hold reset word0", bus.kmersSeq[0], 32'h0);
        chk("hold reset word48", bus.kmersSeq[48], 32'h0);

        // Reset mid-fill, then a clean sequence with no residue.
        send_seq("T", 0, 30);
        chk("midfill count", 32'(bus.baseCount), 32'd30);
        chk("midfill word0", bus.kmersSeq[0], 32'hFFFFFFFF);
        rstN = 1'b1;
        tick();
        rstN = 1'b0;
        chk("midfill reset count", 32'(bus.baseCount), 32'd0);
        chk("midfill reset word0", bus.kmersSeq[0], 32'h0);
        run_vec(6, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
